// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types used by the AddRoundKey stream engine.
package aes_pkg;

  localparam int AES_WORD_W = 32;
  localparam int AES_NB     = 4;
  localparam int AES_NR_MAX = 14;
  localparam int AES_RND_W  = $clog2(AES_NR_MAX + 1);

  typedef enum logic {
    ARK_IDLE = 1'b0,
    ARK_BUSY = 1'b1
  } ark_state_e;

  // Index width that stays legal when a dimension collapses to a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ark_key_store.sv
// Expanded key schedule: NUM_ROUNDS x NUM_WORDS register file, one write port,
// one combinational read port that returns the pre-write value on a collision.
module ark_key_store
  import aes_pkg::*;
#(
  parameter int WORD_W     = AES_WORD_W,
  parameter int NUM_WORDS  = AES_NB,
  parameter int NUM_ROUNDS = AES_NR_MAX + 1,
  parameter int RND_W      = AES_RND_W,
  localparam int IDX_W     = idx_w(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [RND_W-1:0]  wr_round,
  input  logic [IDX_W-1:0]  wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [RND_W-1:0]  rd_round,
  input  logic [IDX_W-1:0]  rd_word,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [NUM_ROUNDS][NUM_WORDS];

  function automatic logic in_range(input logic [RND_W-1:0] r, input logic [IDX_W-1:0] w);
    return (int'(r) < NUM_ROUNDS) && (int'(w) < NUM_WORDS);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROUNDS; r++) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          mem[r][w] <= '0;
        end
      end
    end else if (wr_en && in_range(wr_round, wr_word)) begin
      mem[wr_round][wr_word] <= wr_data;
    end
  end

  // Out-of-range reads return zero so the caller never indexes past the array.
  always_comb begin
    rd_data = '0;
    if (in_range(rd_round, rd_word)) begin
      rd_data = mem[rd_round][rd_word];
    end
  end

endmodule

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey: XORs each state word with the matching round-key word
// and presents it through a single registered valid/ready output stage.
module add_round_key_stream
  import aes_pkg::*;
#(
  parameter int WORD_W     = AES_WORD_W,
  parameter int NUM_WORDS  = AES_NB,
  parameter int NUM_ROUNDS = AES_NR_MAX + 1,
  parameter int RND_W      = AES_RND_W,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = idx_w(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [RND_W-1:0]  key_wr_round,
  input  logic [IDX_W-1:0]  key_wr_word,
  input  logic [WORD_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [RND_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_word_idx,
  output logic              out_last,
  output logic              out_err,
  output logic [CNT_W-1:0]  blocks_done
);

  ark_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;

  logic              accept;
  logic              last_word;
  logic [RND_W-1:0]  rnd_cur;
  logic              rnd_err;
  logic [WORD_W-1:0] key_rd;
  logic [WORD_W-1:0] key_eff;

  logic              vld_p1;
  logic [WORD_W-1:0] data_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic              last_p1;
  logic              err_p1;
  logic [CNT_W-1:0]  done_q;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_word = (cnt_q == IDX_W'(NUM_WORDS - 1));

  // Word 0 of a block takes its round straight from the input; later words use the latch.
  assign rnd_cur = (state_q == ARK_IDLE) ? in_round : rnd_q;
  assign rnd_err = (int'(rnd_cur) >= NUM_ROUNDS);
  assign key_eff = rnd_err ? '0 : key_rd;

  ark_key_store #(
    .WORD_W     (WORD_W),
    .NUM_WORDS  (NUM_WORDS),
    .NUM_ROUNDS (NUM_ROUNDS),
    .RND_W      (RND_W)
  ) u_key_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (key_wr_en),
    .wr_round (key_wr_round),
    .wr_word  (key_wr_word),
    .wr_data  (key_wr_data),
    .rd_round (rnd_cur),
    .rd_word  (cnt_q),
    .rd_data  (key_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARK_IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    if (accept) begin
      if (state_q == ARK_IDLE) begin
        rnd_d = in_round;
      end
      if (last_word) begin
        cnt_d   = '0;
        state_d = ARK_IDLE;
      end else begin
        cnt_d   = cnt_q + IDX_W'(1);
        state_d = ARK_BUSY;
      end
    end
  end

  // Stage p1: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      last_p1 <= 1'b0;
      err_p1  <= 1'b0;
      done_q  <= '0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_data ^ key_eff;
        idx_p1  <= cnt_q;
        last_p1 <= last_word;
        err_p1  <= rnd_err;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
      if (vld_p1 && out_ready && last_p1) begin
        done_q <= done_q + CNT_W'(1);
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_data     = data_p1;
  assign out_word_idx = idx_p1;
  assign out_last     = last_p1;
  assign out_err      = err_p1;
  assign blocks_done  = done_q;

endmodule

// File: doc/add_round_key_stream.md
Name: add_round_key_stream

Overview:
Streaming, parametrised AddRoundKey engine for the AES datapath. It holds a full expanded key schedule of NUM_ROUNDS round keys, each NUM_WORDS words wide, in a local key store. It accepts state words over a valid/ready stream, with the round number sampled on the first word of each block. Each word is XORed with the matching round-key word and emitted through a registered valid/ready output stage.

Parameters:
WORD_W, 32, width of one state/key word in bits
NUM_WORDS, 4, words per state block (AES Nb)
NUM_ROUNDS, 15, round keys held (11/13/15 for AES-128/192/256)
RND_W, 4, width of round index, must satisfy 2^RND_W >= NUM_ROUNDS
CNT_W, 16, width of block completion counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
key_wr_en  in  1  write one key word this cycle
key_wr_round  in  RND_W  round index of key word written
key_wr_word  in  clog2(NUM_WORDS)  word index within round key
key_wr_data  in  WORD_W  key word
in_valid  in  1  input word valid
in_ready  out  1  engine can accept input word
in_data  in  WORD_W  state word
in_round  in  RND_W  round index, sampled only on first word of block
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output word
out_data  out  WORD_W  state word XOR round-key word
out_word_idx  out  clog2(NUM_WORDS)  index of out_data within block
out_last  out  1  out_data is word NUM_WORDS-1 of block
out_err  out  1  this word used an out-of-range round index
blocks_done  out  CNT_W  count of blocks fully emitted, wraps

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_word_idx=0, out_last=0, out_err=0, blocks_done=0, word counter=0, FSM=IDLE, latched round=0, all key store entries=0. Reset mid-block discards the partial block; the next accepted word is word 0.
- in_ready = !out_valid || out_ready (combinational; single output register, full throughput).
- Input accept: in_valid && in_ready. Latency: accepted word appears on out_data the next cycle.
- FSM IDLE: word counter is 0. On accept, latch in_round, use it for this word, advance to BUSY (or stay IDLE if NUM_WORDS=1).
- FSM BUSY: each accept uses the latched round and increments the counter. in_round is ignored. On accepting word NUM_WORDS-1, the counter wraps to 0 and the FSM returns to IDLE.
- XOR: out_data = in_data ^ key[round][word]. If round >= NUM_ROUNDS, key word is treated as 0 (out_data = in_data) and out_err=1 for every word of that block.
- Output hold: while out_valid && !out_ready, out_data, out_word_idx, out_last and out_err are stable. out_valid drops after a transfer if no new word was accepted.
- blocks_done increments by 1 on each output transfer with out_last=1, wrapping from 2^CNT_W-1 to 0.
- Key store: write at address key_wr_round*NUM_WORDS + key_wr_word on key_wr_en. Writes with key_wr_round >= NUM_ROUNDS are ignored.
- Read/write collision on the same entry in the same cycle: the read sees the old value; the new value is visible from the next cycle.
- Key writes are permitted at any time, including mid-block.

Decomposition:
- Shared package aes_pkg: AES_WORD_W=32, AES_NB=4, AES_NR_MAX=14 (so AES_NR_MAX+1 = 15 round keys), and a round-index width constant.
- One sub-module, ark_key_store: NUM_ROUNDS*NUM_WORDS x WORD_W register file with 1 write port and 1 combinational read port, read-old-on-collision.
- The stream FSM, counter and output register stay in the top.

Test Plan:
- FIPS-197 round 0: load key words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c into round 0. Stream 0x3243f6a8, 0x885a308d, 0x313198a2, 0xe0370734 with in_round=0 -> out 0x193de3be, 0xa0f4e22b, 0x9ac68d2a, 0xe9f84808, out_last only on the 4th word, blocks_done=1.
- Round latch: block with in_round=3 on word 0, then in_round toggled to 5 on words 1-3 -> all four words use the round-3 key.
- Backpressure: hold out_ready=0 for 5 cycles mid-block -> in_ready=0, out_data stable, no words lost or duplicated. Full-rate when out_ready=1 -> one word per cycle.
- Out-of-range round: in_round=15 with NUM_ROUNDS=15, in_data 0xdeadbeef -> out_data=0xdeadbeef, out_err=1 for the whole block.
- Collision: write round 0 word 0 = 0xffffffff in the same cycle word 0 of a round-0 block is accepted -> old key used; the next block uses 0xffffffff.
- Reset after 2 words of a block -> out_valid=0, blocks_done=0. The next word is treated as word 0 (new round latched), and the key store reads 0.
